muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2^MUL_UNROLL shift-add multiplier,
// 1-bit/cycle restoring divider, flush kill and a DIV/REM result-reuse cache.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_UNROLL = 1,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [XLEN-1:0]      operand_a_i,
  input  logic [XLEN-1:0]      operand_b_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 kill_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [XLEN-1:0]      result_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFixup, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0]      acc_q, acc_d;
  logic [2:0]             op_q;
  logic [TAG_WIDTH-1:0]   tag_q, tag_out_q;
  logic                   neg_q, sign_a_q, store_q, valid_q;
  logic [XLEN-1:0]        a_q, b_q, a_abs_q, b_abs_q, result_q, result_d;
  logic                   cache_vld_q, cache_sgn_q;
  logic [XLEN-1:0]        cache_a_q, cache_b_q, cache_quot_q, cache_rem_q;

  // Accept-time decode
  logic            accept, is_div, sgn_a_op, sgn_b_op, sa, sb, div_zero, div_ovf, cache_hit;
  logic [XLEN-1:0] a_abs, b_abs;

  assign accept    = start_i & (state_q == StIdle) & ~kill_i;
  assign is_div    = op_i[2];
  assign sgn_a_op  = (op_i == 3'b001) | (op_i == 3'b010) | (is_div & ~op_i[0]);
  assign sgn_b_op  = (op_i == 3'b001) | (is_div & ~op_i[0]);
  assign sa        = sgn_a_op & operand_a_i[XLEN-1];
  assign sb        = sgn_b_op & operand_b_i[XLEN-1];
  assign a_abs     = sa ? -operand_a_i : operand_a_i;
  assign b_abs     = sb ? -operand_b_i : operand_b_i;
  assign div_zero  = is_div & (operand_b_i == '0);
  assign div_ovf   = is_div & ~op_i[0] & (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (operand_b_i == '1);
  assign cache_hit = is_div & cache_vld_q & (operand_a_i == cache_a_q)
                   & (operand_b_i == cache_b_q) & (~op_i[0] == cache_sgn_q);

  // Multiply step: low half of acc holds the remaining multiplier bits
  logic [XLEN+MUL_UNROLL-1:0] partial, mul_sum;
  logic [2*XLEN-1:0]          mul_next;

  always_comb begin
    partial = '0;
    for (int j = 0; j < int'(MUL_UNROLL); j++) begin
      if (acc_q[j]) partial = partial + ({{MUL_UNROLL{1'b0}}, a_abs_q} << j);
    end
    mul_sum  = partial + {{MUL_UNROLL{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    mul_next = {mul_sum, acc_q[XLEN-1:MUL_UNROLL]};
  end

  // Restoring divide step: acc = {remainder, dividend/quotient}
  logic [XLEN:0]     div_trial;
  logic              qbit;
  logic [XLEN-1:0]   div_hi;
  logic [2*XLEN-1:0] div_next;

  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_abs_q};
  assign qbit      = ~div_trial[XLEN];
  assign div_hi    = qbit ? div_trial[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1];
  assign div_next  = {div_hi, acc_q[XLEN-2:0], qbit};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StDone;
          if (div_zero) begin
            acc_d = {operand_a_i, {XLEN{1'b1}}};
          end else if (div_ovf) begin
            acc_d = {{XLEN{1'b0}}, operand_a_i};
          end else if (cache_hit) begin
            acc_d = {cache_rem_q, cache_quot_q};
          end else if (is_div) begin
            state_d = StDiv;
            cnt_d   = CntW'(XLEN - 1);
            acc_d   = {{XLEN{1'b0}}, a_abs};
          end else begin
            state_d = StMul;
            cnt_d   = CntW'(XLEN / MUL_UNROLL - 1);
            acc_d   = {{XLEN{1'b0}}, b_abs};
          end
        end
      end
      StMul, StDiv: begin
        acc_d = (state_q == StMul) ? mul_next : div_next;
        if (cnt_q == '0) state_d = StFixup;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StFixup: begin
        acc_d   = op_q[2] ? {rem_fix, quot_fix} : prod_fix;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill_i) state_d = StIdle;
  end

  always_comb begin
    result_d = result_q;
    case (op_q)
      3'b000, 3'b100, 3'b101: result_d = acc_q[XLEN-1:0];
      default:                result_d = acc_q[2*XLEN-1:XLEN];
    endcase
  end

  logic done_fire;
  assign done_fire = (state_q == StDone) & ~kill_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      acc_q        <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      neg_q        <= 1'b0;
      sign_a_q     <= 1'b0;
      store_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      a_abs_q      <= '0;
      b_abs_q      <= '0;
      valid_q      <= 1'b0;
      result_q     <= '0;
      tag_out_q    <= '0;
      cache_vld_q  <= 1'b0;
      cache_sgn_q  <= 1'b0;
      cache_a_q    <= '0;
      cache_b_q    <= '0;
      cache_quot_q <= '0;
      cache_rem_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= done_fire;
      if (accept) begin
        op_q     <= op_i;
        tag_q    <= tag_i;
        neg_q    <= sa ^ sb;
        sign_a_q <= sa;
        a_q      <= operand_a_i;
        b_q      <= operand_b_i;
        a_abs_q  <= a_abs;
        b_abs_q  <= b_abs;
        store_q  <= is_div & ~div_zero & ~div_ovf & ~cache_hit;
      end
      if (done_fire) begin
        result_q  <= result_d;
        tag_out_q <= tag_q;
        if (store_q) begin
          cache_vld_q  <= 1'b1;
          cache_sgn_q  <= ~op_q[0];
          cache_a_q    <= a_q;
          cache_b_q    <= b_q;
          cache_quot_q <= acc_q[XLEN-1:0];
          cache_rem_q  <= acc_q[2*XLEN-1:XLEN];
        end
      end
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign busy_o   = (state_q != StIdle);
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign tag_o    = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec cases plus randomized ops against
// an arithmetic reference model with its own reuse-cache and latency model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start4, kill;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag;
  logic        ready0, busy0, valid0, ready4, busy4, valid4;
  logic [31:0] result0, result4;
  logic [4:0]  tag0, tag4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit          mc_vld;
  bit          mc_sgn;
  logic [31:0] mc_a, mc_b;
  logic [31:0] last_res0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_UNROLL(1), .TAG_WIDTH(5)) u_dut (
    .clk(clk), .rst(rst), .start_i(start0), .op_i(op), .operand_a_i(a), .operand_b_i(b),
    .tag_i(tag), .kill_i(kill), .ready_o(ready0), .busy_o(busy0), .valid_o(valid0),
    .result_o(result0), .tag_o(tag0)
  );

  muldiv_unit #(.XLEN(32), .MUL_UNROLL(4), .TAG_WIDTH(5)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .op_i(op), .operand_a_i(a), .operand_b_i(b),
    .tag_i(tag), .kill_i(kill), .ready_o(ready4), .busy_o(busy4), .valid_o(valid4),
    .result_o(result4), .tag_o(tag4)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    bit              ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = 64'(x);
    uy  = 64'(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Expected result and latency; divides on the unroll-1 instance update the cache model
  task automatic model(input bit u4, input logic [2:0] o, input logic [31:0] x, y,
                       output logic [31:0] res, output int lat);
    res = ref_res(o, x, y);
    if (!o[2]) lat = u4 ? 10 : 34;
    else if (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) lat = 1;
    else if (mc_vld && mc_a == x && mc_b == y && mc_sgn == !o[0]) lat = 1;
    else begin
      lat = 34;
      if (!u4) begin mc_vld = 1; mc_a = x; mc_b = y; mc_sgn = !o[0]; end
    end
  endtask

  task automatic issue(input bit u4, input logic [2:0] o, input logic [31:0] x, y,
                       input logic [4:0] t);
    @(negedge clk);
    op = o; a = x; b = y; tag = t;
    if (u4) start4 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start4 = 1'b0;
    chk("accept_busy", 32'(u4 ? busy4 : busy0), 32'd1);
  endtask

  task automatic await(input bit u4, input logic [31:0] er, input logic [4:0] et,
                       input int el, input string name);
    int lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (u4 ? valid4 : valid0) begin lat = n; break; end
    end
    chk({name, "_lat"}, lat, el);
    chk({name, "_res"}, u4 ? result4 : result0, er);
    chk({name, "_tag"}, 32'(u4 ? tag4 : tag0), 32'(et));
    if (!u4) last_res0 = er;
    @(posedge clk); #1;
    chk({name, "_pulse"}, 32'(u4 ? valid4 : valid0), 32'd0);
  endtask

  task automatic run(input bit u4, input logic [2:0] o, input logic [31:0] x, y,
                     input logic [4:0] t, input string name);
    logic [31:0] r;
    int          l;
    model(u4, o, x, y, r, l);
    issue(u4, o, x, y, t);
    await(u4, r, t, l, name);
  endtask

  // Spec-given constants; the model still runs to keep its cache in step
  task automatic run_k(input logic [2:0] o, input logic [31:0] x, y, input logic [4:0] t,
                       input logic [31:0] er, input int el, input string name);
    logic [31:0] r;
    int          l;
    model(1'b0, o, x, y, r, l);
    issue(1'b0, o, x, y, t);
    await(1'b0, er, t, el, name);
  endtask

  initial begin
    logic [31:0] r1, r2, pa, pb, ra, rb;
    int          l1, l2;
    bit          seen;
    rst = 1'b1; start0 = 0; start4 = 0; kill = 0; op = 0; a = 0; b = 0; tag = 0;
    mc_vld = 0; mc_sgn = 0; mc_a = 0; mc_b = 0; last_res0 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_result", result0, 32'd0);
    chk("rst_tag", 32'(tag0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_k(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34, "mul");
    run_k(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 34, "mulhu");
    run_k(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34, "div");
    run_k(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 1, "rem_hit");
    run_k(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'd1, 34, "remu");
    run_k(3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, "divu_zero");
    run_k(3'd6, 32'd5, 32'd0, 5'd11, 32'd5, 1, "rem_zero");
    run_k(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, "div_ovf");
    run_k(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1, "rem_ovf");

    // Kill a divide ten cycles in; it must leave no result and no cache entry
    issue(1'b0, 3'd4, 32'd100, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_ready", 32'(ready0), 32'd1);
    chk("kill_busy", 32'(busy0), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid0) seen = 1;
    end
    chk("kill_no_valid", 32'(seen), 32'd0);
    chk("kill_result_held", result0, last_res0);
    @(negedge clk);
    start0 = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; kill = 1'b0;
    chk("kill_start_ignored", 32'(ready0), 32'd1);
    run_k(3'd6, 32'd100, 32'd7, 5'd14, 32'd2, 34, "rem_after_kill");
    run_k(3'd4, 32'd100, 32'd7, 5'd15, 32'd14, 1, "div_hit_after_kill");

    run(1'b1, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, "u4_mul");
    run(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd17, "u4_mulhsu");
    chk("u4_mul_const_check", result4, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      run(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom), "u4_rand");
    end

    pa = 32'd12345; pb = 32'd678;
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel <= 4) begin ra = pa; rb = pb; end
      else if (sel == 5) rb = 32'($urandom_range(1, 255));
      run(1'b0, 3'($urandom_range(0, 7)), ra, rb, 5'($urandom), "rand");
      pa = ra; pb = rb;
    end

    // Reset mid-multiply discards the op and clears the cache
    run(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd18, "pre_rst_div");
    issue(1'b0, 3'd0, 32'd3, 32'd4, 5'd19);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready", 32'(ready0), 32'd1);
    chk("mrst_busy", 32'(busy0), 32'd0);
    chk("mrst_valid", 32'(valid0), 32'd0);
    chk("mrst_result", result0, 32'd0);
    chk("mrst_tag", 32'(tag0), 32'd0);
    mc_vld = 0;
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd20, "post_rst_rem");

    // Back-to-back: start held high, inputs changed right after the first accept
    model(1'b0, 3'd1, 32'h8765_4321, 32'h0000_1234, r1, l1);
    model(1'b0, 3'd5, 32'd1000, 32'd3, r2, l2);
    @(negedge clk);
    op = 3'd1; a = 32'h8765_4321; b = 32'h0000_1234; tag = 5'd21; start0 = 1'b1;
    @(posedge clk); #1;
    chk("b2b_accept1", 32'(busy0), 32'd1);
    op = 3'd5; a = 32'd1000; b = 32'd3; tag = 5'd22;
    await(1'b0, r1, 5'd21, l1, "b2b_first");
    chk("b2b_accept2", 32'(busy0), 32'd1);
    start0 = 1'b0;
    await(1'b0, r2, 5'd22, l2, "b2b_second");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
